cpu5_alu_mc: RTL and testbench

- Multi-cycle execute unit for the cpu5 core.
- Consumes the 3-bit alucontrol code produced by the ALU decoder and the two operands, and returns a registered result plus a zero flag.
- Single-cycle ops (and/or/add/sub/slt) complete in one cycle. Shifts are iterative, one bit per cycle.
- Valid/ready handshakes on both the issue side (decode/regfile) and the result side (writeback/branch logic).

---
 rtl/cpu5_alu_mc.sv | 131 +++++++++++++
 tb/tb_cpu5_alu_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_alu_mc.sv
// cpu5_alu_mc: multi-cycle execute unit. Logic ops, add, sub and slt finish in one cycle;
// shifts iterate one bit per cycle. Valid/ready handshakes on the issue and result sides.
`default_nettype none

module cpu5_alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alucontrol,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_shifted;
  logic [XLEN-1:0] single_res;
  logic [SHW-1:0]  cnt;
  logic [SHW-1:0]  shamt;
  logic [2:0]      op;
  logic            accept;
  logic            is_shift;
  logic            start_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    shamt       = srcb[SHW-1:0];
    accept      = in_valid && (state == IDLE);
    is_shift    = (alucontrol == OP_SLL) || (alucontrol == OP_SRL) || (alucontrol == OP_SRA);
    start_shift = is_shift && (shamt != '0);

    // Shifts by zero fall through to the default and return srca unchanged.
    single_res = srca;
    case (alucontrol)
      OP_AND:  single_res = srca & srcb;
      OP_OR:   single_res = srca | srcb;
      OP_ADD:  single_res = srca + srcb;
      OP_SUB:  single_res = srca - srcb;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: single_res = srca;
    endcase

    case (op)
      OP_SLL:  acc_shifted = {acc[XLEN-2:0], 1'b0};
      OP_SRA:  acc_shifted = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_shifted = {1'b0, acc[XLEN-1:1]};
    endcase

    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SHW'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op     <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              acc <= srca;
              cnt <= shamt;
              op  <= alucontrol;
            end else begin
              result <= single_res;
              zero   <= (single_res == '0);
            end
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result <= acc_shifted;
            zero   <= (acc_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu5_alu_mc.sv
// tb_cpu5_alu_mc: directed vectors for cpu5_alu_mc, checked against literal expectations
// and a cycle-level reference model compared on every falling edge.
`default_nettype none

module tb_cpu5_alu_mc;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alucontrol;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  cpu5_alu_mc #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Architectural reference: what each op must return, straight from the op table.
  function automatic logic [XLEN-1:0] ref_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return a << b[4:0];
      3'b100:  return a >> b[4:0];
      default: return $signed(a) >>> b[4:0];
    endcase
  endfunction

  // Transaction-level model: an op waits out its latency, then is presented until taken.
  logic [XLEN-1:0] m_result;
  logic [XLEN-1:0] m_pending;
  bit              m_zero;
  bit              m_valid;
  int              m_wait;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b0;
      m_wait   = 0;
      m_result = '0;
      m_zero   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid  = 1'b1;
        m_result = m_pending;
        m_zero   = (m_pending == '0);
      end
    end else if (in_valid) begin
      m_pending = ref_op(alucontrol, srca, srcb);
      if ((alucontrol inside {3'b011, 3'b100, 3'b101}) && (srcb[4:0] != 5'd0)) begin
        m_wait = int'(srcb[4:0]);
      end else begin
        m_valid  = 1'b1;
        m_result = m_pending;
        m_zero   = (m_pending == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model in_ready", 64'(in_ready), 64'(!m_valid && m_wait == 0));
      check("model busy", 64'(busy), 64'(m_valid || m_wait != 0));
      check("model out_valid", 64'(out_valid), 64'(m_valid));
      check("model result", 64'(result), 64'(m_result));
      check("model zero", 64'(zero), 64'(m_zero));
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid   = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    out_ready  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    srca     = $urandom;
    srcb     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, 64'(result), 64'(exp));
    check({name, " zero"}, 64'(zero), 64'(exp == '0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    alucontrol = 3'b000;
    srca       = '0;
    srcb       = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;

    run_op("add wrap", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("sub zero", 3'b110, 32'd5, 32'd5, 32'h0, 1);
    run_op("slt neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("slt pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    run_op("or", 3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run_op("sra 4", 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
    run_op("srl 4", 3'b100, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
    run_op("sll 31", 3'b011, 32'd1, 32'd31, 32'h8000_0000, 32);
    run_op("sll mask", 3'b011, 32'h0000_1234, 32'h20, 32'h0000_1234, 1);
    run_op("sra 1", 3'b101, 32'h4000_0000, 32'd1, 32'h2000_0000, 2);
    run_op("srl to zero", 3'b100, 32'd1, 32'd1, 32'h0, 2);

    // Backpressure: result held in DONE while a second op is offered and ignored.
    @(negedge clk);
    in_valid   = 1'b1;
    alucontrol = 3'b010;
    srca       = 32'd100;
    srcb       = 32'd23;
    @(negedge clk);
    check("bp first valid", 64'(out_valid), 64'(1));
    alucontrol = 3'b110;
    srca       = 32'd9;
    srcb       = 32'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp held result", 64'(result), 64'(123));
      check("bp held zero", 64'(zero), 64'(0));
      check("bp in_ready low", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp back to idle", 64'(in_ready), 64'(1));
    check("bp out_valid low", 64'(out_valid), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp pending valid", 64'(out_valid), 64'(1));
    check("bp pending result", 64'(result), 64'(5));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third SHIFT cycle of a 10-bit shift.
    @(negedge clk);
    in_valid   = 1'b1;
    alucontrol = 3'b011;
    srca       = 32'd3;
    srcb       = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst result", 64'(result), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst busy", 64'(busy), 64'(0));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("rst no stale valid", 64'(out_valid), 64'(0));
    end

    run_op("post rst add", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
